regfile_mp: RTL and testbench

Parametrised multi-port register file for the next datapath generation, replacing the single-write, two-read register file. It has NREAD asynchronous read ports, two write ports with byte enables and fixed priority, and optional write-through bypass. A per-register busy scoreboard supports pipelined issue. It sits between decode (reads, reservations) and writeback (writes), with x0 hardwired to zero.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizing helpers and byte-merge logic for regfile_mp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   function automatic int calc_aw(input int regsize);
      return $clog2(regsize);
   endfunction

   function automatic int calc_nb(input int bitsize);
      return bitsize / 8;
   endfunction

   // One byte lane of the two-port write: port 1 (younger) overrides port 0.
   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new0_b,
                                             input logic       en0,
                                             input logic [7:0] new1_b,
                                             input logic       en1);
      logic [7:0] m;
      m = old_b;
      if (en0) m = new0_b;
      if (en1) m = new1_b;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy vector with flush / write-clear / reserve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int REGSIZE = 32,
   localparam int AW      = calc_aw(REGSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         i_wr_act,
   input  logic [2*AW-1:0]    i_wr_sel,
   input  logic               i_rsv_en,
   input  logic [AW-1:0]      i_rsv_sel,
   input  logic               i_flush,
   output logic [REGSIZE-1:0] o_busy
);

   logic [REGSIZE-1:0] r_busy;
   logic [REGSIZE-1:0] w_busy_nxt;

   // Reserve is applied after the write clears so it wins on the same register.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_flush) begin
         w_busy_nxt = '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (i_wr_act[p]) w_busy_nxt[i_wr_sel[p*AW +: AW]] = 1'b0;
         end
         if (i_rsv_en) w_busy_nxt[i_rsv_sel] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_busy <= '0;
      else      r_busy <= w_busy_nxt;
   end

   assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read, dual-write register file with byte enables,
//               optional write-through bypass and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int BITSIZE = 32,
   parameter  int REGSIZE = 32,
   parameter  int NREAD   = 2,
   parameter  int BYPASS  = 1,
   localparam int AW      = calc_aw(REGSIZE),
   localparam int NB      = calc_nb(BITSIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREAD*AW-1:0]      rd_sel,
   output logic [NREAD*BITSIZE-1:0] rd_data,
   output logic [NREAD-1:0]         rd_busy,
   input  logic [1:0]               wr_en,
   input  logic [2*AW-1:0]          wr_sel,
   input  logic [2*BITSIZE-1:0]     wr_data,
   input  logic [2*NB-1:0]          wr_be,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_sel,
   input  logic                     flush
);

   logic [BITSIZE-1:0] r_mem [REGSIZE];
   logic [REGSIZE-1:0] w_busy;
   logic [1:0]         w_act;
   logic [AW-1:0]      w_sel0;
   logic [AW-1:0]      w_sel1;

   assign w_sel0   = wr_sel[0 +: AW];
   assign w_sel1   = wr_sel[AW +: AW];
   // A write to x0 is treated as no write at all, for data and busy alike.
   assign w_act[0] = wr_en[0] && (|wr_be[0 +: NB])  && (w_sel0 != '0);
   assign w_act[1] = wr_en[1] && (|wr_be[NB +: NB]) && (w_sel1 != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < REGSIZE; r++) r_mem[r] <= '0;
      end else begin
         for (int r = 1; r < REGSIZE; r++) begin
            for (int b = 0; b < NB; b++) begin
               r_mem[r][b*8 +: 8] <= merge_byte(
                  r_mem[r][b*8 +: 8],
                  wr_data[b*8 +: 8],
                  w_act[0] && (w_sel0 == AW'(r)) && wr_be[b],
                  wr_data[BITSIZE + b*8 +: 8],
                  w_act[1] && (w_sel1 == AW'(r)) && wr_be[NB + b]);
            end
         end
      end
   end

   regfile_scoreboard #(
      .REGSIZE (REGSIZE)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .i_wr_act  (w_act),
      .i_wr_sel  (wr_sel),
      .i_rsv_en  (rsv_en),
      .i_rsv_sel (rsv_sel),
      .i_flush   (flush),
      .o_busy    (w_busy)
   );

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]      w_rsel;
      logic [BITSIZE-1:0] w_val;

      assign w_rsel = rd_sel[k*AW +: AW];

      always_comb begin
         w_val = r_mem[w_rsel];
         if (BYPASS != 0) begin
            for (int b = 0; b < NB; b++) begin
               w_val[b*8 +: 8] = merge_byte(
                  w_val[b*8 +: 8],
                  wr_data[b*8 +: 8],
                  w_act[0] && (w_sel0 == w_rsel) && wr_be[b],
                  wr_data[BITSIZE + b*8 +: 8],
                  w_act[1] && (w_sel1 == w_rsel) && wr_be[NB + b]);
            end
         end
         if (w_rsel == '0) w_val = '0;
      end

      assign rd_data[k*BITSIZE +: BITSIZE] = w_val;
      assign rd_busy[k]                    = w_busy[w_rsel];
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench for regfile_mp (bypass and non-bypass copies).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

   localparam int NR = 4;
   localparam int AW = 5;
   localparam int W  = 32;
   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [NR*AW-1:0] rd_sel;
   logic [NR*W-1:0]  rd_data_bp, rd_data_nb;
   logic [NR-1:0]    rd_busy_bp, rd_busy_nb;
   logic [1:0]       wr_en;
   logic [2*AW-1:0]  wr_sel;
   logic [2*W-1:0]   wr_data;
   logic [2*NB-1:0]  wr_be;
   logic             rsv_en;
   logic [AW-1:0]    rsv_sel;
   logic             flush;

   regfile_mp #(.BITSIZE(W), .REGSIZE(32), .NREAD(NR), .BYPASS(1)) dut_bp (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_bp), .rd_busy(rd_busy_bp),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush));

   regfile_mp #(.BITSIZE(W), .REGSIZE(32), .NREAD(NR), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush));

   typedef struct packed {
      logic [NR*W-1:0] bp;
      logic [NR*W-1:0] nb;
      logic [NR-1:0]   busy;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_mem [32];
   logic        m_busy [32];
   int          errors = 0;
   int          checks = 0;

   // Next-cycle stimulus, filled in by the directed/random sections.
   logic        n_rst;
   int          n_sel [NR];
   logic [1:0]  n_we;
   int          n_ws [2];
   logic [31:0] n_wd [2];
   logic [3:0]  n_be [2];
   logic        n_re;
   int          n_rs;
   logic        n_fl;

   task automatic clear_next();
      n_rst = 1'b1;
      n_sel = '{0, 0, 0, 0};
      n_we  = 2'b00;
      n_ws  = '{0, 0};
      n_wd  = '{32'h0, 32'h0};
      n_be  = '{4'h0, 4'h0};
      n_re  = 1'b0;
      n_rs  = 0;
      n_fl  = 1'b0;
   endtask

   // Drive one cycle, queue the expected read response, then advance the model.
   task automatic issue();
      exp_t        e;
      logic [31:0] v;
      int          a;
      logic        wr_any [2];
      @(negedge clk);
      rst     = n_rst;
      for (int k = 0; k < NR; k++) rd_sel[k*AW +: AW] = AW'(n_sel[k]);
      wr_en   = n_we;
      wr_sel  = {AW'(n_ws[1]), AW'(n_ws[0])};
      wr_data = {n_wd[1], n_wd[0]};
      wr_be   = {n_be[1], n_be[0]};
      rsv_en  = n_re;
      rsv_sel = AW'(n_rs);
      flush   = n_fl;
      if (!n_rst) begin
         for (int r = 0; r < 32; r++) begin
            m_mem[r]  = 32'h0;
            m_busy[r] = 1'b0;
         end
         return;
      end
      for (int k = 0; k < NR; k++) begin
         a = n_sel[k];
         v = m_mem[a];
         e.nb[k*W +: W] = v;
         if (a != 0) begin
            for (int b = 0; b < 4; b++) begin
               if (n_we[1] && n_ws[1] == a && n_be[1][b])      v[b*8 +: 8] = n_wd[1][b*8 +: 8];
               else if (n_we[0] && n_ws[0] == a && n_be[0][b]) v[b*8 +: 8] = n_wd[0][b*8 +: 8];
            end
         end
         e.bp[k*W +: W] = v;
         e.busy[k]      = m_busy[a];
      end
      exp_q.push_back(e);
      for (int p = 0; p < 2; p++) begin
         wr_any[p] = n_we[p] && (n_be[p] != 4'h0) && (n_ws[p] != 0);
         if (n_we[p] && n_ws[p] != 0)
            for (int b = 0; b < 4; b++)
               if (n_be[p][b] && !(p == 0 && n_we[1] && n_ws[1] == n_ws[0] && n_be[1][b]))
                  m_mem[n_ws[p]][b*8 +: 8] = n_wd[p][b*8 +: 8];
      end
      if (n_fl) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) if (wr_any[p]) m_busy[n_ws[p]] = 1'b0;
         if (n_re && n_rs != 0) m_busy[n_rs] = 1'b1;
      end
   endtask

   // Monitor: every cycle with a queued expectation, compare all read ports.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NR; k++) begin
               checks++;
               if (rd_data_bp[k*W +: W] !== e.bp[k*W +: W]) begin
                  errors++;
                  $display("FAIL rd_data_bypass port%0d sel=%0d t=%0t: actual=%h required=%h",
                           k, rd_sel[k*AW +: AW], $time, rd_data_bp[k*W +: W], e.bp[k*W +: W]);
               end
               checks++;
               if (rd_data_nb[k*W +: W] !== e.nb[k*W +: W]) begin
                  errors++;
                  $display("FAIL rd_data_stored port%0d sel=%0d t=%0t: actual=%h required=%h",
                           k, rd_sel[k*AW +: AW], $time, rd_data_nb[k*W +: W], e.nb[k*W +: W]);
               end
               checks++;
               if (rd_busy_bp[k] !== e.busy[k] || rd_busy_nb[k] !== e.busy[k]) begin
                  errors++;
                  $display("FAIL rd_busy port%0d sel=%0d t=%0t: actual=%b/%b required=%b",
                           k, rd_sel[k*AW +: AW], $time, rd_busy_bp[k], rd_busy_nb[k], e.busy[k]);
               end
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b0; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
      wr_be = '0; rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;

      // Reset held two cycles with both write ports active.
      for (int i = 0; i < 2; i++) begin
         clear_next();
         n_rst = 1'b0; n_we = 2'b11; n_ws = '{5, 6};
         n_wd = '{32'h12345678, 32'h9ABCDEF0}; n_be = '{4'hF, 4'hF};
         n_re = 1'b1; n_rs = 7;
         issue();
      end
      for (int i = 0; i < 8; i++) begin
         clear_next();
         n_sel = '{4*i, 4*i+1, 4*i+2, 4*i+3};
         issue();
      end

      // x0 is immune to writes and reservations.
      clear_next();
      n_we = 2'b01; n_ws = '{0, 0}; n_wd = '{32'hDEADBEEF, 32'h0}; n_be = '{4'hF, 4'h0};
      n_re = 1'b1; n_rs = 0;
      issue();
      clear_next();
      issue();

      // Dual write merging into x5, read in the same cycle and afterwards.
      clear_next();
      n_sel = '{5, 5, 0, 5};
      n_we = 2'b11; n_ws = '{5, 5}; n_wd = '{32'h11223344, 32'hAABBCCDD}; n_be = '{4'hF, 4'h3};
      issue();
      clear_next(); n_sel = '{5, 0, 5, 0}; issue();

      // Scoreboard: reserve, write+reserve, write alone.
      clear_next(); n_sel = '{7, 7, 7, 7}; n_re = 1'b1; n_rs = 7; issue();
      clear_next(); n_sel = '{7, 7, 7, 7};
      n_we = 2'b01; n_ws = '{7, 0}; n_wd = '{32'h00000077, 32'h0}; n_be = '{4'h1, 4'h0};
      n_re = 1'b1; n_rs = 7; issue();
      clear_next(); n_sel = '{7, 7, 7, 7};
      n_we = 2'b10; n_ws = '{0, 7}; n_wd = '{32'h0, 32'h77000000}; n_be = '{4'h0, 4'h8};
      issue();
      clear_next(); n_sel = '{7, 7, 7, 7}; issue();

      // Flush wins over a same-cycle reservation.
      clear_next(); n_re = 1'b1; n_rs = 3; issue();
      clear_next(); n_re = 1'b1; n_rs = 4; issue();
      clear_next(); n_re = 1'b1; n_rs = 9; n_sel = '{3, 4, 9, 10}; issue();
      clear_next(); n_re = 1'b1; n_rs = 10; n_fl = 1'b1; n_sel = '{3, 4, 9, 10}; issue();
      clear_next(); n_sel = '{3, 4, 9, 10}; issue();

      // Independent read ports.
      clear_next();
      n_we = 2'b11; n_ws = '{1, 2}; n_wd = '{32'h1, 32'h2}; n_be = '{4'hF, 4'hF};
      issue();
      clear_next();
      n_we = 2'b01; n_ws = '{31, 0}; n_wd = '{32'hFFFFFFFF, 32'h0}; n_be = '{4'hF, 4'h0};
      n_sel = '{1, 2, 1, 31};
      issue();
      clear_next(); n_sel = '{1, 2, 1, 31}; issue();

      // Randomised traffic, biased toward low registers to force collisions.
      for (int i = 0; i < 800; i++) begin
         clear_next();
         n_rst = ($urandom_range(0, 63) != 0);
         for (int k = 0; k < NR; k++)
            n_sel[k] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
         n_we = 2'($urandom);
         for (int p = 0; p < 2; p++) begin
            n_ws[p] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            n_wd[p] = $urandom;
            n_be[p] = 4'($urandom);
         end
         n_re = 1'($urandom);
         n_rs = $urandom_range(0, 7);
         n_fl = ($urandom_range(0, 15) == 0);
         issue();
      end

      clear_next();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
